rggen_bit_field_rx: RTL and testbench
=====================================

RGGEN_BIT_FIELD_RX -- requirements
Module: rggen_bit_field_rx

Interface
REQ-001 Parameter WIDTH, default 8: field width in bits (>=1).
REQ-002 Parameter INITIAL_VALUE, default '0: WIDTH-bit reset value of the field.
REQ-003 Parameter MODE, default 0: read side effect; 0 = read-to-clear, 1 = read-to-set.
REQ-004 Parameter COUNT_WIDTH, default 4: lost-event counter width (>=1).
REQ-005 Port i_clk, input, 1: sole clock; all state updates on its rising edge.
REQ-006 Port i_rst, input, 1: synchronous, active-high reset.
REQ-007 Port bit_field_if, modport bit_field: uses valid and read_mask; drives read_data and value.
REQ-008 Port i_set, input, WIDTH: per-bit hardware set request.
REQ-009 Port i_clear, input, WIDTH: per-bit hardware clear request.
REQ-010 Port o_value, output, WIDTH: current field register.
REQ-011 Port o_irq, output, 1: OR-reduction of the field register.
REQ-012 Port o_lost_count, output, COUNT_WIDTH: saturating lost-event count.

Function
REQ-013 bit_field_if.read_data, bit_field_if.value and o_value SHALL all equal the field register; o_irq SHALL equal |register, combinationally.
REQ-014 Read hit for bit i, rd[i] = bit_field_if.valid & bit_field_if.read_mask[i]; valid with read_mask == 0 SHALL change nothing.
REQ-015 MODE 0: next[i] = i_set[i] | (value[i] & ~rd[i] & ~i_clear[i]); hardware set wins over read clear and hardware clear in the same cycle.
REQ-016 MODE 1: next[i] = rd[i] | i_set[i] | (value[i] & ~i_clear[i]); any set source wins over i_clear in the same cycle.
REQ-017 Register update SHALL take effect one cycle after the inputs; read_data in the read cycle SHALL return the pre-update value.
REQ-018 A lost event SHALL be any cycle with (i_set & value) != 0, using the pre-update value; at most one increment per cycle regardless of bit count.
REQ-019 Lost counter SHALL increment by 1 per lost-event cycle and saturate at 2^COUNT_WIDTH-1 (no wrap).
REQ-020 Any read access (valid with read_mask != 0) SHALL reset the counter to 0 next cycle; if a lost event occurs in the same cycle, the counter SHALL become 1.
REQ-021 Counter SHALL be mode-independent.

Reset
REQ-022 While i_rst = 1 at a rising edge: register <= INITIAL_VALUE and counter <= 0; reset SHALL override all set, clear and read inputs.
REQ-023 After reset, o_value = INITIAL_VALUE, o_irq = |INITIAL_VALUE and o_lost_count = 0.
REQ-024 Reset asserted mid-operation SHALL discard all pending same-cycle events.

Configuration
REQ-025 Macro RGGEN_BIT_FIELD_RX_LOST_COUNT_EN defined: lost counter implemented per REQ-018..021.
REQ-026 Macro undefined: no counter flops; o_lost_count SHALL be tied to 0; all other behaviour identical.

Verification
REQ-027 WIDTH=8, MODE=0, INITIAL_VALUE=0: i_set=8'h05 for 1 cycle -> o_value=8'h05 and o_irq=1 next cycle; read with read_mask=8'hFF -> read_data=8'h05, then o_value=8'h00.
REQ-028 MODE=0, value=8'h01: same cycle i_set=8'h01 and read with read_mask=8'h01 -> read_data=8'h01, o_value stays 8'h01, and o_lost_count=1 (macro defined).
REQ-029 MODE=1, value=8'h00: read with read_mask=8'h0F -> o_value=8'h0F; then i_clear=8'h03 with a read (read_mask=8'h01) in the same cycle -> o_value=8'h0D.
REQ-030 COUNT_WIDTH=4, value=8'h01: i_set=8'h01 for 20 cycles -> o_lost_count saturates at 15; read with read_mask=8'h01 and no set -> o_lost_count=0.
REQ-031 INITIAL_VALUE=8'hA0: i_set=8'h0F, then i_rst=1 for 1 cycle with i_set=8'hFF -> o_value=8'hA0, o_irq=1, o_lost_count=0; macro undefined -> o_lost_count=0 throughout.

Source files
------------

// File: rtl/rggen_bit_field_rx_if.sv
// Register-bus view of a single bit field: the bus supplies the read strobe and mask,
// the field returns its contents as read_data and value.
interface rggen_bit_field_rx_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic [WIDTH-1:0] read_mask;
  logic [WIDTH-1:0] read_data;
  logic [WIDTH-1:0] value;

  modport bit_field (
    input  valid,
    input  read_mask,
    output read_data,
    output value
  );

  modport master (
    output valid,
    output read_mask,
    input  read_data,
    input  value
  );
endinterface

// File: rtl/rggen_bit_field_rx.sv
// Status bit field with read side effect (MODE 0 read-to-clear, 1 read-to-set), hardware set/clear
// and an optional saturating lost-event counter enabled by macro RGGEN_BIT_FIELD_RX_LOST_COUNT_EN.
module rggen_bit_field_rx #(
  parameter int                WIDTH         = 8,
  parameter logic [WIDTH-1:0]  INITIAL_VALUE = '0,
  parameter int                MODE          = 0,
  parameter int                COUNT_WIDTH   = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  rggen_bit_field_rx_if.bit_field bit_field_if,
  input  logic [WIDTH-1:0]        i_set,
  input  logic [WIDTH-1:0]        i_clear,
  output logic [WIDTH-1:0]        o_value,
  output logic                    o_irq,
  output logic [COUNT_WIDTH-1:0]  o_lost_count
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;
  logic [WIDTH-1:0] rd_s;

  assign rd_s = {WIDTH{bit_field_if.valid}} & bit_field_if.read_mask;

  // Next field value: a hardware set always wins; the read side effect depends on MODE.
  always_comb begin
    value_d = value_q;
    case (MODE)
      32'sd0:  value_d = i_set | (value_q & ~rd_s & ~i_clear);
      32'sd1:  value_d = rd_s | i_set | (value_q & ~i_clear);
      default: value_d = i_set | (value_q & ~rd_s & ~i_clear);
    endcase
  end

  // Field register with synchronous reset to the configured initial value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      value_q <= INITIAL_VALUE;
    end else begin
      value_q <= value_d;
    end
  end

  assign bit_field_if.read_data = value_q;
  assign bit_field_if.value     = value_q;
  assign o_value                = value_q;
  assign o_irq                  = |value_q;

`ifdef RGGEN_BIT_FIELD_RX_LOST_COUNT_EN
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;
  logic                   lost_s;
  logic                   read_hit_s;

  // A set landing on an already-set bit overwrites an unserviced event.
  assign lost_s     = |(i_set & value_q);
  assign read_hit_s = |rd_s;

  // Counter next state: a read restarts counting, and an event in the read cycle is kept.
  always_comb begin
    count_d = count_q;
    if (read_hit_s) begin
      if (lost_s) begin
        count_d = COUNT_WIDTH'(1);
      end else begin
        count_d = '0;
      end
    end else if (lost_s && (count_q != COUNT_MAX)) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Lost-event counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_lost_count = count_q;
`else
  assign o_lost_count = '0;
`endif

endmodule

// File: tb/tb_rggen_bit_field_rx.sv
// Randomized self-checking bench: a read-to-clear (init 00) and a read-to-set (init A0) instance
// share stimulus and are compared against a bit-priority reference model.
module tb_rggen_bit_field_rx;

`ifdef RGGEN_BIT_FIELD_RX_LOST_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam int CNT_MAX = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_set;
  logic [7:0] i_clear;
  logic [7:0] val_o [2];
  logic       irq_o [2];
  logic [3:0] cnt_o [2];
  logic [7:0] rd_obs [2];

  int         mode_of [2];
  logic [7:0] init_of [2];
  logic [7:0] m_val [2];
  int         m_cnt [2];
  int         pass_cnt = 0;
  int         total_cnt = 0;

  rggen_bit_field_rx_if #(.WIDTH(8)) bif0 ();
  rggen_bit_field_rx_if #(.WIDTH(8)) bif1 ();

  rggen_bit_field_rx #(.WIDTH(8), .INITIAL_VALUE(8'h00), .MODE(0), .COUNT_WIDTH(4)) dut0 (
    .i_clk(clk), .i_rst(rst), .bit_field_if(bif0), .i_set(i_set), .i_clear(i_clear),
    .o_value(val_o[0]), .o_irq(irq_o[0]), .o_lost_count(cnt_o[0])
  );

  rggen_bit_field_rx #(.WIDTH(8), .INITIAL_VALUE(8'hA0), .MODE(1), .COUNT_WIDTH(4)) dut1 (
    .i_clk(clk), .i_rst(rst), .bit_field_if(bif1), .i_set(i_set), .i_clear(i_clear),
    .o_value(val_o[1]), .o_irq(irq_o[1]), .o_lost_count(cnt_o[1])
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_next(input int mode, input logic [7:0] cur, input logic [7:0] set,
                                          input logic [7:0] clr, input logic vld, input logic [7:0] mask);
    logic [7:0] nxt;
    nxt = cur;
    for (int b = 0; b < 8; b++) begin
      if (set[b])                          nxt[b] = 1'b1;
      else if (mode == 1 && vld && mask[b]) nxt[b] = 1'b1;
      else if (clr[b])                     nxt[b] = 1'b0;
      else if (mode == 0 && vld && mask[b]) nxt[b] = 1'b0;
      else                                 nxt[b] = cur[b];
    end
    return nxt;
  endfunction

  function automatic int exp_cnt(input int k);
    return CNT_EN ? m_cnt[k] : 0;
  endfunction

  task automatic step(input logic [7:0] set, input logic [7:0] clr, input logic vld,
                      input logic [7:0] mask, input logic r);
    bit lost;
    bit rd_any;
    i_set = set; i_clear = clr; rst = r;
    bif0.valid = vld; bif0.read_mask = mask;
    bif1.valid = vld; bif1.read_mask = mask;
    @(negedge clk);
    rd_obs[0] = bif0.read_data;
    rd_obs[1] = bif1.read_data;
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_val[k] = init_of[k];
        m_cnt[k] = 0;
      end else begin
        lost   = (set & m_val[k]) != 8'h00;
        rd_any = vld && (mask != 8'h00);
        if (rd_any)                     m_cnt[k] = lost ? 1 : 0;
        else if (lost && m_cnt[k] < CNT_MAX) m_cnt[k] = m_cnt[k] + 1;
        m_val[k] = ref_next(mode_of[k], m_val[k], set, clr, vld, mask);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
    total_cnt++; if (val_o[0] !== 8'h00) $display("FAIL reset_value0 got %h exp 00", val_o[0]); else pass_cnt++;
    total_cnt++; if (val_o[1] !== 8'hA0) $display("FAIL reset_value1 got %h exp a0", val_o[1]); else pass_cnt++;
    total_cnt++; if (irq_o[0] !== 1'b0 || irq_o[1] !== 1'b1)
      $display("FAIL reset_irq got %b%b exp 01", irq_o[0], irq_o[1]); else pass_cnt++;
    total_cnt++; if (cnt_o[0] !== 4'd0 || cnt_o[1] !== 4'd0)
      $display("FAIL reset_count got %0d/%0d exp 0/0", cnt_o[0], cnt_o[1]); else pass_cnt++;
  endtask

  task automatic test_read_clear();
    step(8'h05, 8'h00, 1'b0, 8'h00, 1'b0);
    total_cnt++; if (val_o[0] !== 8'h05 || irq_o[0] !== 1'b1)
      $display("FAIL set_value got %h irq %b exp 05 irq 1", val_o[0], irq_o[0]); else pass_cnt++;
    step(8'h00, 8'h00, 1'b1, 8'hFF, 1'b0);
    total_cnt++; if (rd_obs[0] !== 8'h05) $display("FAIL read_data got %h exp 05", rd_obs[0]); else pass_cnt++;
    total_cnt++; if (val_o[0] !== 8'h00) $display("FAIL read_clear got %h exp 00", val_o[0]); else pass_cnt++;
    total_cnt++; if (val_o[1] !== 8'hFF) $display("FAIL read_set_all got %h exp ff", val_o[1]); else pass_cnt++;
  endtask

  task automatic test_set_wins();
    step(8'h01, 8'h00, 1'b0, 8'h00, 1'b0);
    step(8'h01, 8'h00, 1'b1, 8'h01, 1'b0);
    total_cnt++; if (rd_obs[0] !== 8'h01) $display("FAIL set_wins_rdata got %h exp 01", rd_obs[0]); else pass_cnt++;
    total_cnt++; if (val_o[0] !== 8'h01) $display("FAIL set_wins_value got %h exp 01", val_o[0]); else pass_cnt++;
    total_cnt++; if (cnt_o[0] !== (CNT_EN ? 4'd1 : 4'd0))
      $display("FAIL set_wins_count got %0d exp %0d", cnt_o[0], CNT_EN ? 1 : 0); else pass_cnt++;
  endtask

  task automatic test_mask_zero();
    step(8'h00, 8'h00, 1'b1, 8'h00, 1'b0);
    total_cnt++; if (val_o[0] !== 8'h01 || val_o[1] !== m_val[1])
      $display("FAIL mask_zero got %h/%h exp 01/%h", val_o[0], val_o[1], m_val[1]); else pass_cnt++;
    total_cnt++; if (cnt_o[0] !== 4'(exp_cnt(0)))
      $display("FAIL mask_zero_count got %0d exp %0d", cnt_o[0], exp_cnt(0)); else pass_cnt++;
  endtask

  task automatic test_read_set();
    step(8'h00, 8'hFF, 1'b0, 8'h00, 1'b0);
    total_cnt++; if (val_o[1] !== 8'h00) $display("FAIL clear_all got %h exp 00", val_o[1]); else pass_cnt++;
    step(8'h00, 8'h00, 1'b1, 8'h0F, 1'b0);
    total_cnt++; if (val_o[1] !== 8'h0F) $display("FAIL read_set got %h exp 0f", val_o[1]); else pass_cnt++;
    step(8'h00, 8'h03, 1'b1, 8'h01, 1'b0);
    total_cnt++; if (val_o[1] !== 8'h0D) $display("FAIL read_set_vs_clear got %h exp 0d", val_o[1]); else pass_cnt++;
  endtask

  task automatic test_saturate();
    step(8'h01, 8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(8'h01, 8'h00, 1'b0, 8'h00, 1'b0);
      total_cnt++; if (cnt_o[0] !== 4'(exp_cnt(0)) || cnt_o[1] !== 4'(exp_cnt(1)))
        $display("FAIL sat_cycle%0d got %0d/%0d exp %0d/%0d", i, cnt_o[0], cnt_o[1], exp_cnt(0), exp_cnt(1));
      else pass_cnt++;
    end
    total_cnt++; if (cnt_o[0] !== (CNT_EN ? 4'd15 : 4'd0))
      $display("FAIL sat_final got %0d exp %0d", cnt_o[0], CNT_EN ? 15 : 0); else pass_cnt++;
    step(8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
    total_cnt++; if (cnt_o[0] !== 4'd0 || cnt_o[1] !== 4'd0)
      $display("FAIL read_resets_count got %0d/%0d exp 0/0", cnt_o[0], cnt_o[1]); else pass_cnt++;
    total_cnt++; if (val_o[0] !== 8'h00) $display("FAIL sat_read_clear got %h exp 00", val_o[0]); else pass_cnt++;
  endtask

  task automatic test_reset_override();
    step(8'h0F, 8'h00, 1'b0, 8'h00, 1'b0);
    step(8'hFF, 8'h00, 1'b1, 8'hFF, 1'b1);
    total_cnt++; if (val_o[1] !== 8'hA0 || irq_o[1] !== 1'b1)
      $display("FAIL rst_override1 got %h irq %b exp a0 irq 1", val_o[1], irq_o[1]); else pass_cnt++;
    total_cnt++; if (val_o[0] !== 8'h00 || irq_o[0] !== 1'b0)
      $display("FAIL rst_override0 got %h irq %b exp 00 irq 0", val_o[0], irq_o[0]); else pass_cnt++;
    total_cnt++; if (cnt_o[0] !== 4'd0 || cnt_o[1] !== 4'd0)
      $display("FAIL rst_override_count got %0d/%0d exp 0/0", cnt_o[0], cnt_o[1]); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [7:0] pre [2];
    logic [7:0] set;
    logic [7:0] clr;
    logic [7:0] mask;
    for (int i = 0; i < 300; i++) begin
      pre[0] = m_val[0];
      pre[1] = m_val[1];
      set  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      clr  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      mask = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      step(set, clr, 1'($urandom), mask, $urandom_range(0, 31) == 0);
      for (int k = 0; k < 2; k++) begin
        total_cnt++; if (rd_obs[k] !== pre[k])
          $display("FAIL rnd_rdata%0d cyc%0d got %h exp %h", k, i, rd_obs[k], pre[k]); else pass_cnt++;
        total_cnt++; if (val_o[k] !== m_val[k] || irq_o[k] !== (m_val[k] != 8'h00))
          $display("FAIL rnd_value%0d cyc%0d got %h irq %b exp %h", k, i, val_o[k], irq_o[k], m_val[k]);
        else pass_cnt++;
        total_cnt++; if (cnt_o[k] !== 4'(exp_cnt(k)))
          $display("FAIL rnd_count%0d cyc%0d got %0d exp %0d", k, i, cnt_o[k], exp_cnt(k)); else pass_cnt++;
      end
    end
  endtask

  initial begin
    mode_of[0] = 0; init_of[0] = 8'h00;
    mode_of[1] = 1; init_of[1] = 8'hA0;
    m_val[0] = 8'h00; m_val[1] = 8'h00;
    m_cnt[0] = 0; m_cnt[1] = 0;
    test_reset();
    test_read_clear();
    test_set_wins();
    test_mask_zero();
    test_read_set();
    test_saturate();
    test_reset_override();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
